// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_fire_scheduler
//  Description : Round-robin fire controller for the invader formation.
//                Picks the next alive column and claims a free slot in a
//                shared projectile pool. Moves every live projectile down the
//                screen each cycle.
//  Option      : define ENEMY_FIRE_STATS_EN to build the 16-bit saturating
//                shots_fired counter. Without it, shots_fired is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_fire_scheduler #(
   parameter int N_SHOOTERS  = 5,
   parameter int N_SLOTS     = 3,
   parameter int FIRE_PERIOD = 512,
   parameter int COL_SPACING = 40,
   parameter int SPAWN_DY    = 20,
   parameter int STEP        = 2,
   parameter int Y_LIMIT     = 480
) (
   input  logic                    clk_4,
   input  logic                    clr_n,
   input  logic                    play,
   input  logic [N_SHOOTERS-1:0]   alive,
   input  logic [9:0]              formation_x,
   input  logic [9:0]              formation_y,
   output logic [10*N_SLOTS-1:0]   proj_x,
   output logic [10*N_SLOTS-1:0]   proj_y,
   output logic [N_SLOTS-1:0]      proj_valid,
   output logic [N_SHOOTERS-1:0]   fire_grant,
   output logic [15:0]             shots_fired
);

   localparam int TW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
   localparam int CW = (N_SHOOTERS  > 1) ? $clog2(N_SHOOTERS)  : 1;
   localparam int SW = (N_SLOTS     > 1) ? $clog2(N_SLOTS)     : 1;

   localparam logic [TW-1:0] C_TIMER_LAST = TW'(FIRE_PERIOD - 1);
   localparam logic [CW-1:0] C_COL_LAST   = CW'(N_SHOOTERS - 1);
   localparam logic [9:0]    C_STEP       = 10'(STEP);
   localparam logic [9:0]    C_Y_LIMIT    = 10'(Y_LIMIT);
   localparam logic [9:0]    C_SPAWN_DY   = 10'(SPAWN_DY);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_PICK  = 2'd2,
      S_SPAWN = 2'd3
   } state_t;

   state_t                 state_q,  state_d;
   logic [TW-1:0]          timer_q,  timer_d;
   logic [CW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]          col_q,    col_d;
   logic [SW-1:0]          slot_q,   slot_d;
   logic [N_SHOOTERS-1:0]  grant_q,  grant_d;
   logic [N_SLOTS-1:0]     valid_q,  valid_d;
   logic [9:0]             slot_x_q [N_SLOTS];
   logic [9:0]             slot_x_d [N_SLOTS];
   logic [9:0]             slot_y_q [N_SLOTS];
   logic [9:0]             slot_y_d [N_SLOTS];

   logic                   col_any;
   logic                   col_hi;
   logic [CW-1:0]          col_low_all;
   logic [CW-1:0]          col_low_hi;
   logic [CW-1:0]          col_pick;
   logic                   slot_free;
   logic [SW-1:0]          slot_pick;

   // Circular search of alive from rr_ptr, and lowest free slot.
   // Both loops run high-to-low so the last hit is the lowest index.
   always_comb begin
      col_any     = 1'b0;
      col_hi      = 1'b0;
      col_low_all = '0;
      col_low_hi  = '0;
      for (int j = N_SHOOTERS - 1; j >= 0; j--) begin
         if (alive[j]) begin
            col_any     = 1'b1;
            col_low_all = CW'(j);
            if (CW'(j) >= rr_ptr_q) begin
               col_hi     = 1'b1;
               col_low_hi = CW'(j);
            end
         end
      end
      col_pick  = col_hi ? col_low_hi : col_low_all;
      slot_free = 1'b0;
      slot_pick = '0;
      for (int s = N_SLOTS - 1; s >= 0; s--) begin
         if (!valid_q[s]) begin
            slot_free = 1'b1;
            slot_pick = SW'(s);
         end
      end
   end

   // Next-state logic: FSM, slot load/motion, and the play-low clear
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      rr_ptr_d = rr_ptr_q;
      col_d    = col_q;
      slot_d   = slot_q;
      grant_d  = '0;
      valid_d  = valid_q;
      slot_x_d = slot_x_q;
      slot_y_d = slot_y_q;

      // The slot claimed in PICK is loaded on the SPAWN exit edge; every
      // other live slot falls, retiring once the next y passes the limit.
      if (state_q != S_IDLE) begin
         for (int s = 0; s < N_SLOTS; s++) begin
            if (state_q == S_SPAWN && slot_q == SW'(s)) begin
               valid_d[s]  = 1'b1;
               slot_x_d[s] = formation_x + 10'(int'(col_q) * COL_SPACING);
               slot_y_d[s] = formation_y + C_SPAWN_DY;
            end else if (valid_q[s]) begin
               if (slot_y_q[s] + C_STEP > C_Y_LIMIT) begin
                  valid_d[s]  = 1'b0;
                  slot_x_d[s] = '0;
                  slot_y_d[s] = '0;
               end else begin
                  slot_y_d[s] = slot_y_q[s] + C_STEP;
               end
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            state_d = S_WAIT;
            timer_d = '0;
         end
         S_WAIT: begin
            if (timer_q == C_TIMER_LAST) begin
               timer_d = '0;
               state_d = S_PICK;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_PICK: begin
            if (col_any && slot_free) begin
               col_d            = col_pick;
               slot_d           = slot_pick;
               grant_d[col_pick] = 1'b1;
               state_d          = S_SPAWN;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_SPAWN: begin
            rr_ptr_d = (col_q == C_COL_LAST) ? '0 : col_q + 1'b1;
            state_d  = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase

      // Dropping play wins over everything, including a pending SPAWN
      if (!play) begin
         state_d  = S_IDLE;
         timer_d  = '0;
         rr_ptr_d = '0;
         col_d    = '0;
         slot_d   = '0;
         grant_d  = '0;
         valid_d  = '0;
         for (int s = 0; s < N_SLOTS; s++) begin
            slot_x_d[s] = '0;
            slot_y_d[s] = '0;
         end
      end
   end

   // State registers with synchronous active-low clear
   always_ff @(posedge clk_4) begin
      if (!clr_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         rr_ptr_q <= '0;
         col_q    <= '0;
         slot_q   <= '0;
         grant_q  <= '0;
         valid_q  <= '0;
         for (int s = 0; s < N_SLOTS; s++) begin
            slot_x_q[s] <= '0;
            slot_y_q[s] <= '0;
         end
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         rr_ptr_q <= rr_ptr_d;
         col_q    <= col_d;
         slot_q   <= slot_d;
         grant_q  <= grant_d;
         valid_q  <= valid_d;
         for (int s = 0; s < N_SLOTS; s++) begin
            slot_x_q[s] <= slot_x_d[s];
            slot_y_q[s] <= slot_y_d[s];
         end
      end
   end

   generate
      for (genvar s = 0; s < N_SLOTS; s++) begin : g_pack
         assign proj_x[10*s +: 10] = slot_x_q[s];
         assign proj_y[10*s +: 10] = slot_y_q[s];
      end
   endgenerate

   assign proj_valid = valid_q;
   assign fire_grant = grant_q;

`ifdef ENEMY_FIRE_STATS_EN
   logic [15:0] shots_q, shots_d;

   // Saturating count of committed shots since leaving IDLE
   always_comb begin
      shots_d = shots_q;
      if (!play) begin
         shots_d = '0;
      end else if (state_q == S_SPAWN && shots_q != 16'hFFFF) begin
         shots_d = shots_q + 16'd1;
      end
   end

   // Shot counter register
   always_ff @(posedge clk_4) begin
      if (!clr_n) begin
         shots_q <= '0;
      end else begin
         shots_q <= shots_d;
      end
   end

   assign shots_fired = shots_q;
`else
   assign shots_fired = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_fire_scheduler
//  Description : Directed, table-driven bench for enemy_fire_scheduler with
//                FIRE_PERIOD = 8, plus hand sequences for play drop, the
//                retire boundary and reset mid-flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_fire_scheduler;

   localparam int FP = 8;

   logic        clk_4 = 1'b0;
   logic        clr_n = 1'b0;
   logic        play  = 1'b0;
   logic [4:0]  alive = '0;
   logic [9:0]  formation_x = 10'd100;
   logic [9:0]  formation_y = 10'd400;
   logic [29:0] proj_x;
   logic [29:0] proj_y;
   logic [2:0]  proj_valid;
   logic [4:0]  fire_grant;
   logic [15:0] shots_fired;

   int n_tests = 0;
   int n_fail  = 0;

   enemy_fire_scheduler #(
      .N_SHOOTERS  (5),
      .N_SLOTS     (3),
      .FIRE_PERIOD (FP),
      .COL_SPACING (40),
      .SPAWN_DY    (20),
      .STEP        (2),
      .Y_LIMIT     (480)
   ) u_dut (
      .clk_4       (clk_4),
      .clr_n       (clr_n),
      .play        (play),
      .alive       (alive),
      .formation_x (formation_x),
      .formation_y (formation_y),
      .proj_x      (proj_x),
      .proj_y      (proj_y),
      .proj_valid  (proj_valid),
      .fire_grant  (fire_grant),
      .shots_fired (shots_fired)
   );

   always #5 clk_4 = ~clk_4;

   typedef struct {
      logic [4:0] alive;
      logic [4:0] grant;
      int         slot;
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] valid;
      int         shots;
   } vec_t;

   vec_t tbl [12];

   task automatic tick();
      @(posedge clk_4);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int exp_shots(input int n);
`ifdef ENEMY_FIRE_STATS_EN
      return n;
`else
      return 0;
`endif
   endfunction

   // From a sync point (just after entering WAIT with timer 0): run one fire
   // decision and return the grant seen in the SPAWN cycle (0 if none).
   // Ends at the next sync point.
   task automatic do_decision(input logic [4:0] a, output logic [4:0] g);
      logic early;
      early = 1'b0;
      alive = a;
      for (int k = 0; k < FP; k++) begin
         tick();
         if (fire_grant != '0) early = 1'b1;
      end
      check("no_grant_before_spawn", {31'd0, early}, 32'd0);
      tick();
      g = fire_grant;
      if (g != '0) tick();
   endtask

   initial begin
      logic [4:0] g;

      // r: alive, grant, slot, x, y, valid-after, shots-after (formation 100/400)
      tbl[0]  = '{5'b11111, 5'b00001,  0, 10'd100, 10'd420, 3'b001, 1};
      tbl[1]  = '{5'b11111, 5'b00010,  1, 10'd140, 10'd420, 3'b011, 2};
      tbl[2]  = '{5'b11111, 5'b00100,  2, 10'd180, 10'd420, 3'b111, 3};
      tbl[3]  = '{5'b11111, 5'b00000, -1, 10'd0,   10'd0,   3'b111, 3};
      tbl[4]  = '{5'b11111, 5'b01000,  0, 10'd220, 10'd420, 3'b111, 4};
      tbl[5]  = '{5'b10100, 5'b10000,  1, 10'd260, 10'd420, 3'b111, 5};
      tbl[6]  = '{5'b10100, 5'b00100,  2, 10'd180, 10'd420, 3'b111, 6};
      tbl[7]  = '{5'b10100, 5'b00000, -1, 10'd0,   10'd0,   3'b111, 6};
      tbl[8]  = '{5'b00000, 5'b00000, -1, 10'd0,   10'd0,   3'b110, 6};
      tbl[9]  = '{5'b00000, 5'b00000, -1, 10'd0,   10'd0,   3'b100, 6};
      tbl[10] = '{5'b10100, 5'b10000,  0, 10'd260, 10'd420, 3'b001, 7};
      tbl[11] = '{5'b10100, 5'b00100,  1, 10'd180, 10'd420, 3'b011, 8};

      // Reset state
      tick();
      tick();
      check("rst_valid", {29'd0, proj_valid}, 32'd0);
      check("rst_x",     {2'd0, proj_x}, 32'd0);
      check("rst_y",     {2'd0, proj_y}, 32'd0);
      check("rst_grant", {27'd0, fire_grant}, 32'd0);
      check("rst_shots", {16'd0, shots_fired}, 32'd0);

      clr_n = 1'b1;
      play  = 1'b1;
      tick();   // IDLE -> WAIT: sync point

      // Table run
      for (int i = 0; i < 12; i++) begin
         do_decision(tbl[i].alive, g);
         check($sformatf("r%0d_grant", i), {27'd0, g}, {27'd0, tbl[i].grant});
         check($sformatf("r%0d_valid", i), {29'd0, proj_valid}, {29'd0, tbl[i].valid});
         check($sformatf("r%0d_shots", i), {16'd0, shots_fired}, exp_shots(tbl[i].shots));
         if (tbl[i].slot >= 0) begin
            check($sformatf("r%0d_x", i), {22'd0, proj_x[10*tbl[i].slot +: 10]}, {22'd0, tbl[i].x});
            check($sformatf("r%0d_y", i), {22'd0, proj_y[10*tbl[i].slot +: 10]}, {22'd0, tbl[i].y});
         end
      end

      // play drop in the PICK cycle abandons the shot and clears everything
      alive       = 5'b11111;
      formation_y = 10'd456;
      for (int k = 0; k < FP; k++) tick();
      play = 1'b0;
      tick();
      check("drop_grant", {27'd0, fire_grant}, 32'd0);
      check("drop_valid", {29'd0, proj_valid}, 32'd0);
      check("drop_x",     {2'd0, proj_x}, 32'd0);
      check("drop_y",     {2'd0, proj_y}, 32'd0);
      check("drop_shots", {16'd0, shots_fired}, 32'd0);
      play = 1'b1;
      tick();
      do_decision(5'b11111, g);
      check("restart_grant", {27'd0, g}, 32'b00001);
      check("restart_y",     {22'd0, proj_y[9:0]}, 32'd476);

      // Retire boundary: 478 -> 480 stays live, then 482 > 480 retires
      tick();
      tick();
      check("edge480_valid", {31'd0, proj_valid[0]}, 32'd1);
      check("edge480_y",     {22'd0, proj_y[9:0]}, 32'd480);
      tick();
      check("retire_valid", {31'd0, proj_valid[0]}, 32'd0);
      check("retire_x",     {22'd0, proj_x[9:0]}, 32'd0);
      check("retire_y",     {22'd0, proj_y[9:0]}, 32'd0);

      // Reset mid-flight with two live slots
      play = 1'b0;
      tick();
      play        = 1'b1;
      formation_y = 10'd10;
      tick();
      do_decision(5'b11111, g);
      check("mf_grant0", {27'd0, g}, 32'b00001);
      check("mf_y0",     {22'd0, proj_y[9:0]}, 32'd30);
      do_decision(5'b11111, g);
      check("mf_grant1", {27'd0, g}, 32'b00010);
      check("mf_x1",     {22'd0, proj_x[19:10]}, 32'd140);
      check("mf_valid",  {29'd0, proj_valid}, 32'b011);
      check("mf_shots",  {16'd0, shots_fired}, exp_shots(2));
      clr_n = 1'b0;
      tick();
      check("mf_rst_valid", {29'd0, proj_valid}, 32'd0);
      check("mf_rst_x",     {2'd0, proj_x}, 32'd0);
      check("mf_rst_y",     {2'd0, proj_y}, 32'd0);
      check("mf_rst_grant", {27'd0, fire_grant}, 32'd0);
      check("mf_rst_shots", {16'd0, shots_fired}, 32'd0);
      clr_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
